// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU word size and function codes
package alu_pkg;

    localparam int WORD_W = 64;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_XOR = 4'h3
    } alu_fn_e;

endpackage

// File: rtl/sub_if.sv
// rtl/sub_if.sv - operand/result bundle between the ALU operand source and the subtractor
interface sub_if
    import alu_pkg::*;
#(
    parameter int WIDTH = WORD_W
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic             carry_overflow;

    modport master (
        output A,
        output B,
        input  result,
        input  carry_overflow
    );

    modport slave (
        input  A,
        input  B,
        output result,
        output carry_overflow
    );
endinterface

// File: rtl/sub_full_adder.sv
// rtl/sub_full_adder.sv - one-bit full adder cell of the subtractor ripple chain
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end
endmodule

// File: rtl/sub.sv
// rtl/sub.sv - registered signed subtractor: result = A - B via A + ~B + 1, with signed overflow
module sub
    import alu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic  clk,
    input  logic  rst,
    sub_if.slave  bus
);
    logic [WIDTH-1:0] b_inv;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   carry;
    logic             ovf;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_overflow_d, carry_overflow_q;

    assign b_inv    = ~bus.B;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (bus.A[i]),
            .b    (b_inv[i]),
            .cin  (carry[i]),
            .sum  (diff[i]),
            .cout (carry[i+1])
        );
    end

    // Carry into and out of the sign bit disagree exactly when the operand signs differ
    // and the difference sign departs from A's, i.e. signed overflow (not borrow).
    assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

    always_comb begin
        result_d         = diff;
        carry_overflow_d = ovf;
        if (rst) begin
            result_d         = '0;
            carry_overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        result_q         <= result_d;
        carry_overflow_q <= carry_overflow_d;
    end

    assign bus.result         = result_q;
    assign bus.carry_overflow = carry_overflow_q;
endmodule

// File: tb/tb_sub.sv
// tb/tb_sub.sv - randomized and directed self-checking bench for sub against an arithmetic model
module tb_sub;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sub_if #(.WIDTH(W)) bus ();

    sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return a - b;
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W+1:0] wide;
        logic signed [W+1:0] lo;
        logic signed [W+1:0] hi;
        wide = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
        hi = (66'sd1 <<< (W-1)) - 66'sd1;
        lo = -(66'sd1 <<< (W-1));
        return (wide > hi) || (wide < lo);
    endfunction

    task automatic apply(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        @(posedge clk);
        #1;
        check({tag, "_res"}, bus.result, model_diff(a, b));
        check({tag, "_ovf"}, {{(W-1){1'b0}}, bus.carry_overflow}, {{(W-1){1'b0}}, model_ovf(a, b)});
    endtask

    localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG1 = {W{1'b1}};

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        bus.A = 64'd4;
        bus.B = 64'd1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        check("reset_res", bus.result, '0);
        check("reset_ovf", {{(W-1){1'b0}}, bus.carry_overflow}, '0);
        @(negedge clk);
        rst = 1'b0;

        apply("t1", 64'd4, 64'd1);
        check("t1_const", bus.result, 64'd3);
        apply("t2", 64'd0, NEG1);
        check("t2_const", bus.result, 64'd1);
        apply("t3", 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
        check("t3_const", bus.result, 64'h0000_0001_FFFF_FFFF);
        apply("t4", MIN, 64'd1);
        check("t4_const", bus.result, MAX);
        check("t4_ovf_const", {{(W-1){1'b0}}, bus.carry_overflow}, 64'd1);
        apply("t5", MAX, NEG1);
        check("t5_const", bus.result, MIN);
        check("t5_ovf_const", {{(W-1){1'b0}}, bus.carry_overflow}, 64'd1);
        apply("zero_min", 64'd0, MIN);
        check("zero_min_ovf_const", {{(W-1){1'b0}}, bus.carry_overflow}, 64'd1);
        apply("eq", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
        apply("minus0", MIN, 64'd0);
        apply("min_min", MIN, MIN);
        apply("max_min", MAX, MIN);
        apply("min_max", MIN, MAX);

        // Reset mid-stream discards the in-flight value and resumes on the next edge.
        @(negedge clk);
        bus.A = 64'd4;
        bus.B = 64'd1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_res", bus.result, '0);
        check("midrst_ovf", {{(W-1){1'b0}}, bus.carry_overflow}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_res", bus.result, 64'd3);

        for (int i = 0; i < 300; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case (i % 6)
                0: ra[W-1] = ~rb[W-1];
                1: rb = ra;
                2: rb = {$urandom_range(1, 0) ? NEG1 : 64'd0};
                3: ra = {ra[W-1], {(W-1){ra[W-1] ? 1'b0 : 1'b1}}};
                default: ;
            endcase
            apply("rand", ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
